// File: rtl/proc_pkg.sv
// proc_pkg: opcode and ALU-op constants, the rstatus register number and the
// instruction field positions shared by the five-stage pipeline control logic.
package proc_pkg;

  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;
  localparam logic [4:0] OP_ALU = 5'b00000;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] RSTATUS_REG = 5'd30;

  localparam int FLD_OPC_HI   = 31;
  localparam int FLD_OPC_LO   = 27;
  localparam int FLD_RD_HI    = 26;
  localparam int FLD_RD_LO    = 22;
  localparam int FLD_RS_HI    = 21;
  localparam int FLD_RS_LO    = 17;
  localparam int FLD_RT_HI    = 16;
  localparam int FLD_RT_LO    = 12;
  localparam int FLD_SHAMT_HI = 11;
  localparam int FLD_SHAMT_LO = 7;
  localparam int FLD_ALUOP_HI = 6;
  localparam int FLD_ALUOP_LO = 2;

endpackage

// File: rtl/hazard_src_decode.sv
// hazard_src_decode: maps the F/D instruction to the two register-file read
// ports it will use and classifies it as load, store or mul/div.
module hazard_src_decode
  import proc_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b,
  output logic        is_load,
  output logic        is_store,
  output logic        is_multdiv
);

  logic [4:0] opcode;
  logic [4:0] alu_op;
  logic       unused_ir;

  assign opcode    = ir[FLD_OPC_HI:FLD_OPC_LO];
  assign alu_op    = ir[FLD_ALUOP_HI:FLD_ALUOP_LO];
  assign unused_ir = ^{ir[FLD_SHAMT_HI:FLD_SHAMT_LO], ir[1:0]};

  assign is_load    = (opcode == OP_LW);
  assign is_store   = (opcode == OP_SW);
  assign is_multdiv = (opcode == OP_ALU) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

  // bex reads rstatus on A; stores and rd-comparing branches read rd on B
  always_comb begin
    src_a = ir[FLD_RS_HI:FLD_RS_LO];
    src_b = ir[FLD_RT_HI:FLD_RT_LO];
    if (opcode == OP_BEX) begin
      src_a = RSTATUS_REG;
    end
    case (opcode)
      OP_SW, OP_BNE, OP_JR, OP_BLT: src_b = ir[FLD_RD_HI:FLD_RD_LO];
      default: ;
    endcase
  end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// load_hazard_scoreboard: per-register down-counters track loads still in
// flight so the decode stage stalls until their data can be bypassed.
// Optional macro SCOREBOARD_MULTDIV_EN adds per-register mul/div pending flags
// cleared by multdiv_done; without it mul/div hazards rely on pw_stall alone.
module load_hazard_scoreboard
  import proc_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MEM_LAT  = 1,
  parameter int CNT_W    = $clog2(MEM_LAT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         fd_ir,
  input  logic                fd_valid,
  input  logic                flush,
  input  logic                pw_stall,
  input  logic                multdiv_done,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                hazard_rs,
  output logic                hazard_rt
);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("load_hazard_scoreboard: MEM_LAT must be at least 1");
  end

  logic [4:0]       src_a;
  logic [4:0]       src_b;
  logic [4:0]       rd;
  logic             is_load;
  logic             is_store;
  logic             is_multdiv;
  logic             busy_a;
  logic             busy_b;
  logic             md_a;
  logic             md_b;
  logic             md_conflict;
  logic             issue;
  logic             set_load;
  logic [CNT_W-1:0] cnt [NUM_REGS];

  hazard_src_decode u_decode (
    .ir         (fd_ir),
    .src_a      (src_a),
    .src_b      (src_b),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_multdiv (is_multdiv)
  );

  assign rd = fd_ir[FLD_RD_HI:FLD_RD_LO];

  // A store's data arriving in the load's final cycle is caught by the W->M
  // bypass, so a store only waits while more than one cycle remains.
  assign busy_a = (cnt[src_a] != '0);
  assign busy_b = is_store ? (cnt[src_b] > CNT_W'(1)) : (cnt[src_b] != '0);

`ifdef SCOREBOARD_MULTDIV_EN
  logic [NUM_REGS-1:0] md_pending;
  logic [NUM_REGS-1:0] md_next;

  assign md_a        = md_pending[src_a];
  assign md_b        = md_pending[src_b];
  assign md_conflict = fd_valid & is_multdiv & (|md_pending);
`else
  logic unused_md;

  assign md_a        = 1'b0;
  assign md_b        = 1'b0;
  assign md_conflict = 1'b0;
  assign unused_md   = multdiv_done ^ is_multdiv;
`endif

  assign hazard_rs = fd_valid & (src_a != 5'd0) & (busy_a | md_a);
  assign hazard_rt = fd_valid & (src_b != 5'd0) & (busy_b | md_b);
  assign stall     = pw_stall | ((hazard_rs | hazard_rt | md_conflict) & ~flush);
  assign issue     = fd_valid & ~stall & ~flush & ~pw_stall;
  assign set_load  = issue & is_load & (rd != 5'd0);

  // Load issue reloads its destination counter; all other counters drain
  // once per unfrozen cycle and stop at zero. Flush leaves them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_load && (int'(rd) == i)) begin
          cnt[i] <= CNT_W'(MEM_LAT);
        end else if (!pw_stall && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

`ifdef SCOREBOARD_MULTDIV_EN
  // Only one mul/div is ever in flight, so completion clears every flag
  // before a newly issued mul/div marks its destination.
  always_comb begin
    md_next = multdiv_done ? '0 : md_pending;
    if (issue && is_multdiv && (rd != 5'd0)) begin
      md_next[rd] = 1'b1;
    end
  end

  // Pending mul/div flags register
  always_ff @(posedge clock) begin
    if (reset) begin
      md_pending <= '0;
    end else begin
      md_pending <= md_next;
    end
  end
`endif

  // Debug view of which registers are still waiting on a result
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef SCOREBOARD_MULTDIV_EN
      pending_mask[i] = (cnt[i] != '0) | md_pending[i];
`else
      pending_mask[i] = (cnt[i] != '0);
`endif
    end
  end

endmodule
